// File: rtl/arp_tbl_arbiter_if.sv
// Requester and table-port signal bundle for arp_tbl_arbiter.
// slave = arbiter side, master = requesters plus the ARP table.
interface arp_tbl_arbiter_if #(
    parameter int DATA_WIDTH = 96,
    parameter int ADDR_WIDTH = 5
);
    logic                  sw_req;
    logic                  sw_we;
    logic [ADDR_WIDTH-1:0] sw_addr;
    logic [DATA_WIDTH-1:0] sw_wdata;
    logic                  sw_ack;
    logic                  sw_err;
    logic [DATA_WIDTH-1:0] sw_rdata;

    logic                  hw_req;
    logic                  hw_we;
    logic [ADDR_WIDTH-1:0] hw_addr;
    logic [DATA_WIDTH-1:0] hw_wdata;
    logic                  hw_ack;
    logic                  hw_err;
    logic [DATA_WIDTH-1:0] hw_rdata;

    logic                  tbl_rd_req;
    logic                  tbl_wr_req;
    logic [ADDR_WIDTH-1:0] tbl_rd_addr;
    logic [ADDR_WIDTH-1:0] tbl_wr_addr;
    logic [DATA_WIDTH-1:0] tbl_wr_data;
    logic [DATA_WIDTH-1:0] tbl_rd_data;
    logic                  tbl_rd_ack;
    logic                  tbl_wr_ack;

    modport slave (
        input  sw_req, sw_we, sw_addr, sw_wdata,
        output sw_ack, sw_err, sw_rdata,
        input  hw_req, hw_we, hw_addr, hw_wdata,
        output hw_ack, hw_err, hw_rdata,
        output tbl_rd_req, tbl_wr_req, tbl_rd_addr, tbl_wr_addr, tbl_wr_data,
        input  tbl_rd_data, tbl_rd_ack, tbl_wr_ack
    );

    modport master (
        output sw_req, sw_we, sw_addr, sw_wdata,
        input  sw_ack, sw_err, sw_rdata,
        output hw_req, hw_we, hw_addr, hw_wdata,
        input  hw_ack, hw_err, hw_rdata,
        input  tbl_rd_req, tbl_wr_req, tbl_rd_addr, tbl_wr_addr, tbl_wr_data,
        output tbl_rd_data, tbl_rd_ack, tbl_wr_ack
    );
endinterface

// File: rtl/arp_tbl_arbiter.sv
// Round-robin SW/HW arbiter and one-at-a-time sequencer for the single-port ARP table.
// Optional WAIT-state abort is enabled by defining ARP_ARB_TIMEOUT_EN.
module arp_tbl_arbiter #(
    parameter int DATA_WIDTH     = 96,
    parameter int ADDR_WIDTH     = 5,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      AXI_ACLK,
    input  logic                      reset,
    arp_tbl_arbiter_if.slave          bus,
    output logic                      busy,
    output logic [15:0]               timeout_count
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  gnt_hw_q, gnt_hw_d;
    logic                  last_hw_q, last_hw_d;
    logic [DATA_WIDTH-1:0] sw_rdata_q, sw_rdata_d;
    logic [DATA_WIDTH-1:0] hw_rdata_q, hw_rdata_d;

`ifdef ARP_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic                  err_q, err_d;
    logic [15:0]           tmo_cnt_q, tmo_cnt_d;
`endif

    logic match_ack;
    logic pick_hw;
    logic done_sw;
    logic done_hw;

    assign match_ack = we_q ? bus.tbl_wr_ack : bus.tbl_rd_ack;
    // Under contention the requester not served last wins; otherwise the lone requester.
    assign pick_hw   = (bus.sw_req && bus.hw_req) ? !last_hw_q : bus.hw_req;

    always_comb begin
        // NOTE: every signal gets its hold value first, so no path through the case leaves one unassigned (no latch).
        state_d    = state_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        gnt_hw_d   = gnt_hw_q;
        last_hw_d  = last_hw_q;
        sw_rdata_d = sw_rdata_q;
        hw_rdata_d = hw_rdata_q;
`ifdef ARP_ARB_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        tmo_cnt_d  = tmo_cnt_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (bus.sw_req || bus.hw_req) begin
                    gnt_hw_d = pick_hw;
                    we_d     = pick_hw ? bus.hw_we    : bus.sw_we;
                    addr_d   = pick_hw ? bus.hw_addr  : bus.sw_addr;
                    wdata_d  = pick_hw ? bus.hw_wdata : bus.sw_wdata;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
`ifdef ARP_ARB_TIMEOUT_EN
                wait_cnt_d = '0;
                err_d      = 1'b0;
`endif
            end
            S_WAIT: begin
                if (match_ack) begin
                    state_d = S_DONE;
                    if (!we_q) begin
                        if (gnt_hw_q) hw_rdata_d = bus.tbl_rd_data;
                        else          sw_rdata_d = bus.tbl_rd_data;
                    end
                end
`ifdef ARP_ARB_TIMEOUT_EN
                // A matching ack on the final count takes priority over the abort.
                else if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = S_DONE;
                    err_d   = 1'b1;
                    if (tmo_cnt_q != 16'hFFFF) tmo_cnt_d = tmo_cnt_q + 16'd1;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
`endif
            end
            S_DONE: begin
                last_hw_d = gnt_hw_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge AXI_ACLK) begin
        if (reset) begin
            // NOTE: the rdata result registers are plain flops, not a RAM, so they reset with everything else.
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            gnt_hw_q   <= 1'b0;
            last_hw_q  <= 1'b1;
            sw_rdata_q <= '0;
            hw_rdata_q <= '0;
`ifdef ARP_ARB_TIMEOUT_EN
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
            tmo_cnt_q  <= '0;
`endif
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of every other flop.
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            gnt_hw_q   <= gnt_hw_d;
            last_hw_q  <= last_hw_d;
            sw_rdata_q <= sw_rdata_d;
            hw_rdata_q <= hw_rdata_d;
`ifdef ARP_ARB_TIMEOUT_EN
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
            tmo_cnt_q  <= tmo_cnt_d;
`endif
        end
    end

    // Every output is decoded from registered state only.
    assign busy            = (state_q != S_IDLE);
    assign done_sw         = (state_q == S_DONE) && !gnt_hw_q;
    assign done_hw         = (state_q == S_DONE) &&  gnt_hw_q;

    assign bus.sw_ack      = done_sw;
    assign bus.hw_ack      = done_hw;
    assign bus.sw_rdata    = sw_rdata_q;
    assign bus.hw_rdata    = hw_rdata_q;

    assign bus.tbl_rd_req  = (state_q == S_ISSUE) && !we_q;
    assign bus.tbl_wr_req  = (state_q == S_ISSUE) &&  we_q;
    assign bus.tbl_rd_addr = addr_q;
    assign bus.tbl_wr_addr = addr_q;
    assign bus.tbl_wr_data = wdata_q;

`ifdef ARP_ARB_TIMEOUT_EN
    assign bus.sw_err      = done_sw && err_q;
    assign bus.hw_err      = done_hw && err_q;
    assign timeout_count   = tmo_cnt_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign bus.sw_err      = 1'b0;
    assign bus.hw_err      = 1'b0;
    assign timeout_count   = 16'h0000;
`endif

endmodule

// File: tb/tb_arp_tbl_arbiter.sv
// Scoreboard bench for arp_tbl_arbiter: directed transactions push expected table requests
// and completions; a negedge monitor pops and compares whenever the DUT presents one.
module tb_arp_tbl_arbiter;

    localparam logic [95:0] ENTRY3 = 96'h0000A1B2C3D4E5F60A000001;
    localparam logic [95:0] W_SW   = 96'h111122223333444455556666;
    localparam logic [95:0] W_HW   = 96'hC0FFEE00123456789ABCDEF0;
    localparam logic [95:0] W_5A   = 96'h5A5A5A5A5A5A5A5A5A5A5A5A;
    localparam logic [95:0] JUNK   = 96'hDEADBEEFDEADBEEFDEADBEEF;

    typedef struct {
        bit          is_hw;
        bit          err;
        logic [95:0] rdata;
        int          cyc;
    } ack_exp_t;

    typedef struct {
        bit          we;
        logic [4:0]  addr;
        logic [95:0] wdata;
        int          cyc;
    } tbl_exp_t;

    typedef enum {M_NORMAL, M_NEVER, M_WRONG} mode_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        busy;
    logic [15:0] timeout_count;
    logic        model_rd_ack;
    logic        force_rd_ack;

    int          cyc = 0;
    int          n;
    int          n_tests = 0;
    int          n_fail = 0;
    mode_t       mode = M_NORMAL;
    logic [95:0] mem [32];
    ack_exp_t    ack_q[$];
    tbl_exp_t    tbl_q[$];
    ack_exp_t    ae;
    tbl_exp_t    te;

    arp_tbl_arbiter_if #(.DATA_WIDTH(96), .ADDR_WIDTH(5)) bus ();

    arp_tbl_arbiter #(
        .DATA_WIDTH(96),
        .ADDR_WIDTH(5),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .AXI_ACLK      (clk),
        .reset         (reset),
        .bus           (bus),
        .busy          (busy),
        .timeout_count (timeout_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign bus.tbl_rd_ack = model_rd_ack | force_rd_ack;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic drive(input bit is_hw, input bit req, input bit we,
                         input logic [4:0] addr, input logic [95:0] wdata);
        if (is_hw) begin
            bus.hw_req = req; bus.hw_we = we; bus.hw_addr = addr; bus.hw_wdata = wdata;
        end else begin
            bus.sw_req = req; bus.sw_we = we; bus.sw_addr = addr; bus.sw_wdata = wdata;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},       busy,            0);
        check({tag, "_tbl_rd_req"}, bus.tbl_rd_req,  0);
        check({tag, "_tbl_wr_req"}, bus.tbl_wr_req,  0);
        check({tag, "_sw_ack"},     bus.sw_ack,      0);
        check({tag, "_hw_ack"},     bus.hw_ack,      0);
        check({tag, "_sw_err"},     bus.sw_err,      0);
        check({tag, "_hw_err"},     bus.hw_err,      0);
        check({tag, "_sw_rdata"},   bus.sw_rdata,    0);
        check({tag, "_hw_rdata"},   bus.hw_rdata,    0);
        check({tag, "_rd_addr"},    bus.tbl_rd_addr, 0);
        check({tag, "_wr_addr"},    bus.tbl_wr_addr, 0);
        check({tag, "_wr_data"},    bus.tbl_wr_data, 0);
        check({tag, "_tmo_count"},  timeout_count,   0);
    endtask

    // One uncontended transaction: request, table request one cycle later, completion ack_lat later.
    task automatic run_txn(input bit is_hw, input bit we, input logic [4:0] addr,
                           input logic [95:0] wdata, input logic [95:0] exp_rdata, input int ack_lat);
        @(negedge clk);
        n = cyc;
        drive(is_hw, 1'b1, we, addr, wdata);
        tbl_q.push_back('{we, addr, wdata, n + 1});
        ack_q.push_back('{is_hw, 1'b0, exp_rdata, n + ack_lat});
        wait_until(n + ack_lat);
        drive(is_hw, 1'b0, 1'b0, 5'd0, 96'd0);
        wait_until(n + ack_lat + 1);
    endtask

    // Table model: registered ack one cycle after the request, or delayed / missing per mode.
    initial begin : table_model
        logic       rd;
        logic [4:0] ra;
        model_rd_ack    = 1'b0;
        bus.tbl_wr_ack  = 1'b0;
        bus.tbl_rd_data = JUNK;
        forever begin
            @(negedge clk);
            if (bus.tbl_wr_req) mem[bus.tbl_wr_addr] = bus.tbl_wr_data;
            if ((bus.tbl_rd_req || bus.tbl_wr_req) && mode != M_NEVER) begin
                rd = bus.tbl_rd_req;
                ra = bus.tbl_rd_addr;
                if (mode == M_WRONG) begin
                    @(posedge clk); #1;
                    if (rd) bus.tbl_wr_ack = 1'b1; else model_rd_ack = 1'b1;
                    @(posedge clk); #1;
                    bus.tbl_wr_ack = 1'b0; model_rd_ack = 1'b0;
                    @(posedge clk); #1;
                end else begin
                    @(posedge clk); #1;
                end
                if (rd) begin
                    model_rd_ack    = 1'b1;
                    bus.tbl_rd_data = mem[ra];
                end else begin
                    bus.tbl_wr_ack  = 1'b1;
                end
                @(posedge clk); #1;
                model_rd_ack    = 1'b0;
                bus.tbl_wr_ack  = 1'b0;
                bus.tbl_rd_data = JUNK;
            end
        end
    end

    // Monitor: compares each presented table request and requester completion against the queues.
    always @(negedge clk) begin
        if (bus.tbl_rd_req || bus.tbl_wr_req) begin
            if (tbl_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_tbl_req at cycle %0d: rd=%b wr=%b, none expected",
                         cyc, bus.tbl_rd_req, bus.tbl_wr_req);
            end else begin
                te = tbl_q.pop_front();
                check("tbl_cycle",   cyc, te.cyc);
                check("tbl_one_req", bus.tbl_rd_req & bus.tbl_wr_req, 0);
                check("tbl_is_wr",   bus.tbl_wr_req, te.we);
                check("tbl_addr",    te.we ? bus.tbl_wr_addr : bus.tbl_rd_addr, te.addr);
                if (te.we) check("tbl_wr_data", bus.tbl_wr_data, te.wdata);
            end
        end
        if (bus.sw_ack || bus.hw_ack) begin
            if (ack_q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_ack at cycle %0d: sw_ack=%b hw_ack=%b, none expected",
                         cyc, bus.sw_ack, bus.hw_ack);
            end else begin
                ae = ack_q.pop_front();
                check("ack_cycle", cyc, ae.cyc);
                check("ack_both",  bus.sw_ack & bus.hw_ack, 0);
                check("ack_is_hw", bus.hw_ack, ae.is_hw);
                check("ack_err",   ae.is_hw ? bus.hw_err   : bus.sw_err,   ae.err);
                check("ack_rdata", ae.is_hw ? bus.hw_rdata : bus.sw_rdata, ae.rdata);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        reset        = 1'b1;
        force_rd_ack = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 5'd0, 96'd0);
        drive(1'b1, 1'b0, 1'b0, 5'd0, 96'd0);
        for (int i = 0; i < 32; i++) mem[i] = 96'd0;
        mem[3] = ENTRY3;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Contention: both write continuously; SW wins first, then strict alternation.
        @(negedge clk);
        n = cyc;
        drive(1'b0, 1'b1, 1'b1, 5'd1, W_SW);
        drive(1'b1, 1'b1, 1'b1, 5'd2, W_HW);
        for (int k = 0; k < 4; k++) begin
            tbl_q.push_back('{1'b1, (k % 2 == 0) ? 5'd1 : 5'd2, (k % 2 == 0) ? W_SW : W_HW, n + 1 + 4 * k});
            ack_q.push_back('{(k % 2 == 1), 1'b0, 96'd0, n + 3 + 4 * k});
        end
        wait_until(n + 15);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 96'd0);
        drive(1'b1, 1'b0, 1'b0, 5'd0, 96'd0);
        wait_until(n + 17);
        check("idle_after_contention", busy, 0);

        // SW read of entry 3.
        run_txn(1'b0, 1'b0, 5'd3, 96'd0, ENTRY3, 3);
        check("sw_rdata_entry3", bus.sw_rdata, ENTRY3);
        check("hw_rdata_untouched", bus.hw_rdata, 0);

        // HW read of what contention wrote, then a HW write that must leave hw_rdata alone.
        run_txn(1'b1, 1'b0, 5'd2, 96'd0, W_HW, 3);
        run_txn(1'b1, 1'b1, 5'd7, W_5A, W_HW, 3);
        check("hw_rdata_after_write", bus.hw_rdata, W_HW);
        check("sw_rdata_after_hw_write", bus.sw_rdata, ENTRY3);

        // Wrong ack type first: completion only after the real read ack two cycles later.
        mode = M_WRONG;
        run_txn(1'b0, 1'b0, 5'd1, 96'd0, W_SW, 5);
        mode = M_NORMAL;
        check("sw_rdata_wrong_ack", bus.sw_rdata, W_SW);

        // Reset while in WAIT: no completion, everything cleared, held request served afresh.
        @(negedge clk);
        n = cyc;
        mode = M_NEVER;
        drive(1'b0, 1'b1, 1'b0, 5'd7, 96'd0);
        tbl_q.push_back('{1'b0, 5'd7, 96'd0, n + 1});
        wait_until(n + 3);
        check("busy_in_wait", busy, 1);
        reset = 1'b1;
        wait_until(n + 4);
        check_all_zero("reset_mid");
        reset        = 1'b0;
        force_rd_ack = 1'b1;
        mode         = M_NORMAL;
        tbl_q.push_back('{1'b0, 5'd7, 96'd0, n + 5});
        ack_q.push_back('{1'b0, 1'b0, W_5A, n + 7});
        wait_until(n + 5);
        force_rd_ack = 1'b0;
        wait_until(n + 7);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 96'd0);
        wait_until(n + 8);
        check("sw_rdata_reserved", bus.sw_rdata, W_5A);

`ifdef ARP_ARB_TIMEOUT_EN
        // Table never answers: abort after 16 WAIT cycles, late ack ignored.
        @(negedge clk);
        n = cyc;
        mode = M_NEVER;
        drive(1'b0, 1'b1, 1'b0, 5'd3, 96'd0);
        tbl_q.push_back('{1'b0, 5'd3, 96'd0, n + 1});
        ack_q.push_back('{1'b0, 1'b1, W_5A, n + 18});
        wait_until(n + 18);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 96'd0);
        check("timeout_count_one", timeout_count, 16'd1);
        wait_until(n + 20);
        force_rd_ack = 1'b1;
        wait_until(n + 21);
        force_rd_ack = 1'b0;
        mode = M_NORMAL;
        wait_until(n + 24);
        check("idle_after_late_ack", busy, 0);
        check("timeout_count_held", timeout_count, 16'd1);
        check("sw_rdata_after_timeout", bus.sw_rdata, W_5A);
`else
        // Table never answers: without the abort feature the arbiter waits indefinitely.
        @(negedge clk);
        n = cyc;
        mode = M_NEVER;
        drive(1'b0, 1'b1, 1'b0, 5'd3, 96'd0);
        tbl_q.push_back('{1'b0, 5'd3, 96'd0, n + 1});
        wait_until(n + 40);
        check("busy_held_no_ack", busy, 1);
        check("timeout_count_tied", timeout_count, 16'd0);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 96'd0);
        reset = 1'b1;
        wait_until(n + 42);
        reset = 1'b0;
        mode  = M_NORMAL;
        wait_until(n + 44);
        check("idle_after_cleanup", busy, 0);
`endif

        wait_until(cyc + 4);
        check("ack_queue_drained", ack_q.size(), 0);
        check("tbl_queue_drained", tbl_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
